clock_divider_bank: RTL and testbench

Runtime-programmable bank of `CHANNELS` independent 50%-duty clock dividers, all driven from the single system clock. It generalises the fixed per-purpose dividers with per-channel divisors, glitch-free divisor reload at half-period boundaries, immediate stop and start, and a global phase-align pulse. Each channel also produces a one-cycle `tick` strobe on every divided-clock rising edge. Control logic (LCD, audio, keyboard) uses the bank to retune rates at run time.

---
 rtl/clock_divider_bank.sv | 115 +++++++++++
 tb/tb_clock_divider_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of runtime-programmable 50% duty clock dividers
module clock_divider_bank #(
    parameter int CHANNELS         = 8,
    parameter int CH_WIDTH         = 3,
    parameter int DIV_WIDTH        = 24,
    parameter int DEFAULT_DIV_HALF = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_wr,
    input  logic [CH_WIDTH-1:0]  cfg_ch,
    input  logic [DIV_WIDTH-1:0] cfg_div_half,
    input  logic                 sync,
    output logic                 cfg_err,
    output logic [CHANNELS-1:0]  pending,
    output logic [CHANNELS-1:0]  clk_div,
    output logic [CHANNELS-1:0]  tick
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV_HALF);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    logic [31:0] ch_ext;
    logic        ch_valid;
    logic        wr_zero;

    assign ch_ext   = 32'(cfg_ch);
    assign ch_valid = ch_ext < 32'(CHANNELS);
    assign wr_zero  = cfg_div_half == '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !ch_valid;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DIV_WIDTH-1:0] active;
        logic [DIV_WIDTH-1:0] pend_val;
        logic [DIV_WIDTH-1:0] cnt;
        logic                 pend;
        logic                 div_q;
        logic                 tick_q;
        logic                 wr_hit;
        logic                 running;
        logic                 at_toggle;

        assign wr_hit    = cfg_wr && (ch_ext == 32'(c));
        assign running   = active != '0;
        assign at_toggle = running && (cnt == active - ONE);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                active   <= DEF_DIV;
                pend_val <= '0;
                cnt      <= '0;
                pend     <= 1'b0;
                div_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (sync) begin
                    // A write coinciding with sync bypasses the pending slot.
                    if (wr_hit) begin
                        active <= cfg_div_half;
                        pend   <= 1'b0;
                        cnt    <= '0;
                        div_q  <= 1'b0;
                    end else if (running) begin
                        if (pend) begin
                            active <= pend_val;
                        end
                        pend  <= 1'b0;
                        cnt   <= '0;
                        div_q <= 1'b0;
                    end
                end else if (wr_hit && wr_zero) begin
                    active <= '0;
                    pend   <= 1'b0;
                    cnt    <= '0;
                    div_q  <= 1'b0;
                end else if (wr_hit && !running) begin
                    active <= cfg_div_half;
                    pend   <= 1'b0;
                    cnt    <= '0;
                end else if (running) begin
                    if (at_toggle) begin
                        cnt    <= '0;
                        div_q  <= ~div_q;
                        tick_q <= ~div_q;
                        if (pend) begin
                            active <= pend_val;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                    // On a toggle edge the old pend_val is consumed above; a new write refills the slot.
                    if (wr_hit) begin
                        pend_val <= cfg_div_half;
                        pend     <= 1'b1;
                    end else if (at_toggle) begin
                        pend <= 1'b0;
                    end
                end
            end
        end

        assign clk_div[c] = div_q;
        assign tick[c]    = tick_q;
        assign pending[c] = pend;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - randomized check of clock_divider_bank against an event-time model
module tb_clock_divider_bank;

    localparam int NCH = 8;
    localparam int CHW = 4;
    localparam int DW  = 24;
    localparam int DEF = 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           cfg_wr = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [DW-1:0]  cfg_div_half = '0;
    logic           sync = 1'b0;
    logic           cfg_err;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] clk_div;
    logic [NCH-1:0] tick;

    clock_divider_bank #(
        .CHANNELS(NCH), .CH_WIDTH(CHW), .DIV_WIDTH(DW), .DEFAULT_DIV_HALF(DEF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div_half(cfg_div_half), .sync(sync), .cfg_err(cfg_err),
        .pending(pending), .clk_div(clk_div), .tick(tick)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Model: each running channel is described by the absolute edge number of its next toggle.
    longint edge_no;
    longint m_act  [NCH];
    longint m_pval [NCH];
    bit     m_pend [NCH];
    bit     m_lvl  [NCH];
    bit     m_tick [NCH];
    longint m_next [NCH];
    bit     m_err;

    task automatic model_reset();
        edge_no = 0;
        m_err   = 0;
        for (int c = 0; c < NCH; c++) begin
            m_act[c]  = DEF;
            m_pval[c] = 0;
            m_pend[c] = 0;
            m_lvl[c]  = 0;
            m_tick[c] = 0;
            m_next[c] = DEF;
        end
    endtask

    task automatic model_edge(input bit wr, input int ch, input longint val, input bit sy);
        bit hit;
        edge_no++;
        m_err = wr && (ch >= NCH);
        for (int c = 0; c < NCH; c++) begin
            hit = wr && (ch == c);
            m_tick[c] = 0;
            if (sy) begin
                if (hit) begin
                    m_act[c] = val;
                    m_pend[c] = 0;
                    m_lvl[c] = 0;
                    m_next[c] = edge_no + val;
                end else if (m_act[c] > 0) begin
                    if (m_pend[c]) m_act[c] = m_pval[c];
                    m_pend[c] = 0;
                    m_lvl[c] = 0;
                    m_next[c] = edge_no + m_act[c];
                end
            end else if (hit && val == 0) begin
                m_act[c] = 0;
                m_pend[c] = 0;
                m_lvl[c] = 0;
            end else if (hit && m_act[c] == 0) begin
                m_act[c] = val;
                m_lvl[c] = 0;
                m_next[c] = edge_no + val;
            end else if (m_act[c] > 0) begin
                if (edge_no == m_next[c]) begin
                    m_lvl[c] = !m_lvl[c];
                    m_tick[c] = m_lvl[c];
                    if (m_pend[c]) begin
                        m_act[c] = m_pval[c];
                        m_pend[c] = 0;
                    end
                    m_next[c] = edge_no + m_act[c];
                end
                if (hit) begin
                    m_pend[c] = 1;
                    m_pval[c] = val;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0] e_div, e_tick, e_pend;
        for (int c = 0; c < NCH; c++) begin
            e_div[c]  = m_lvl[c];
            e_tick[c] = m_tick[c];
            e_pend[c] = m_pend[c];
        end
        check("clk_div", 32'(clk_div), 32'(e_div));
        check("tick", 32'(tick), 32'(e_tick));
        check("pending", 32'(pending), 32'(e_pend));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic step(input bit wr, input int ch, input longint val, input bit sy);
        cfg_wr = wr;
        cfg_ch = CHW'(ch);
        cfg_div_half = DW'(val);
        sync = sy;
        @(posedge clk);
        model_edge(wr, ch, val, sy);
        #1;
        cfg_wr = 0;
        sync = 0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        reset_n = 1;
        #1;

        idle(8);
        step(1, 0, 0, 0);
        step(1, 0, 3, 0);
        idle(14);
        step(1, 1, 4, 0);
        idle(9);
        step(1, 1, 2, 0);
        idle(12);
        step(1, 2, 3, 0);
        idle(5);
        step(1, 2, 0, 0);
        idle(6);
        step(1, 2, 5, 0);
        idle(22);
        step(1, 3, 3, 0);
        idle(2);
        step(1, 4, 6, 0);
        idle(5);
        step(0, 0, 0, 1);
        idle(30);
        step(1, 5, 7, 1);
        idle(4);
        step(1, 6, 0, 1);
        idle(4);
        step(1, 7, 24'hFFFFFF, 0);
        idle(3);
        step(1, 9, 2, 0);
        idle(3);

        for (int i = 0; i < 2500; i++) begin
            bit     wr;
            int     ch;
            longint val;
            bit     sy;
            wr  = ($urandom_range(0, 5) == 0);
            ch  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            val = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(1, 9));
            sy  = ($urandom_range(0, 60) == 0);
            step(wr, ch, val, sy);
        end

        step(1, 1, 5, 0);
        idle(3);
        #2;
        reset_n = 0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset_n = 1;
        #1;
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
